rx_byte_sync: RTL and testbench

//  Receive-side byte aligner/filter between the deserializer and the lane demux.

---
 rtl/rx_byte_sync_if.sv | 40 ++++
 rtl/rx_byte_sync.sv | 122 ++++++++++++
 tb/tb_rx_byte_sync.sv | 139 +++++++++++++
 3 files changed

// File: rtl/rx_byte_sync_if.sv
// Byte stream bundle between the deserializer, rx_byte_sync and the lane demux.
// Optional payload_cnt is present only when RX_SYNC_STATS_EN is defined.
interface rx_byte_sync_if;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic [7:0]  data_out;
  logic        valid_out;
  logic        active;
`ifdef RX_SYNC_STATS_EN
  logic [15:0] payload_cnt;
`else
  // no statistics signal in this build
`endif

  // master: raw byte source, consumes the filtered stream
  modport master (
    output byte_in,
    output byte_valid,
    input  data_out,
    input  valid_out,
`ifdef RX_SYNC_STATS_EN
    input  payload_cnt,
`else
`endif
    input  active
  );

  // slave: the aligner/filter itself
  modport slave (
    input  byte_in,
    input  byte_valid,
    output data_out,
    output valid_out,
`ifdef RX_SYNC_STATS_EN
    output payload_cnt,
`else
`endif
    output active
  );
endinterface

// File: rtl/rx_byte_sync.sv
// rx_byte_sync: receive-side comma aligner and comma/idle filter on clk_2f.
// Locks after SYNC_COUNT consecutive valid commas, forwards payload bytes only,
// drops lock after LOSS_CYCLES consecutive cycles without byte_valid.
// Optional macro RX_SYNC_STATS_EN adds a saturating forwarded-byte counter.
module rx_byte_sync #(
  parameter logic [7:0]  COMMA       = 8'hBC,
  parameter logic [7:0]  IDLE        = 8'h7C,
  parameter int unsigned SYNC_COUNT  = 4,
  parameter int unsigned LOSS_CYCLES = 8
) (
  input  logic          clk_2f,
  input  logic          reset,
  rx_byte_sync_if.slave bus
);

  localparam int unsigned CW = (SYNC_COUNT  < 1) ? 1 : $clog2(SYNC_COUNT + 1);
  localparam int unsigned GW = (LOSS_CYCLES < 1) ? 1 : $clog2(LOSS_CYCLES + 1);
  localparam logic [CW-1:0] C_LAST = CW'(SYNC_COUNT - 1);
  localparam logic [GW-1:0] G_LAST = GW'(LOSS_CYCLES - 1);

  typedef enum logic {ST_UNSYNC, ST_SYNC} state_t;

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_comma_cnt, w_comma_cnt_nxt;
  logic [GW-1:0] r_gap_cnt, w_gap_cnt_nxt;
  logic [7:0]    r_data_out, w_data_nxt;
  logic          r_valid_out, w_valid_nxt;
  logic          r_active, w_active_nxt;
  logic          w_is_comma, w_is_idle;

  assign w_is_comma = (bus.byte_in == COMMA);
  assign w_is_idle  = (bus.byte_in == IDLE);

  // Next-state, counter and output decode
  always_comb begin
    w_state_nxt     = r_state;
    w_comma_cnt_nxt = r_comma_cnt;
    w_gap_cnt_nxt   = r_gap_cnt;
    w_data_nxt      = r_data_out;
    w_valid_nxt     = 1'b0;
    case (r_state)
      ST_UNSYNC: begin
        // gaps leave the comma run untouched
        if (bus.byte_valid) begin
          if (w_is_comma) begin
            if (r_comma_cnt == C_LAST) begin
              w_state_nxt     = ST_SYNC;
              w_comma_cnt_nxt = '0;
              w_gap_cnt_nxt   = '0;
            end else begin
              w_comma_cnt_nxt = r_comma_cnt + CW'(1);
            end
          end else begin
            w_comma_cnt_nxt = '0;
          end
        end
      end
      ST_SYNC: begin
        if (bus.byte_valid) begin
          w_gap_cnt_nxt = '0;
          if (!w_is_comma && !w_is_idle) begin
            w_data_nxt  = bus.byte_in;
            w_valid_nxt = 1'b1;
          end
        end else if (r_gap_cnt == G_LAST) begin
          w_state_nxt     = ST_UNSYNC;
          w_gap_cnt_nxt   = '0;
          w_comma_cnt_nxt = '0;
        end else begin
          w_gap_cnt_nxt = r_gap_cnt + GW'(1);
        end
      end
      default: begin
        w_state_nxt     = ST_UNSYNC;
        w_comma_cnt_nxt = '0;
        w_gap_cnt_nxt   = '0;
      end
    endcase
    w_active_nxt = (w_state_nxt == ST_SYNC);
  end

  // State, counters and registered outputs
  always_ff @(posedge clk_2f) begin
    if (!reset) begin
      r_state     <= ST_UNSYNC;
      r_comma_cnt <= '0;
      r_gap_cnt   <= '0;
      r_data_out  <= '0;
      r_valid_out <= 1'b0;
      r_active    <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_comma_cnt <= w_comma_cnt_nxt;
      r_gap_cnt   <= w_gap_cnt_nxt;
      r_data_out  <= w_data_nxt;
      r_valid_out <= w_valid_nxt;
      r_active    <= w_active_nxt;
    end
  end

  assign bus.data_out  = r_data_out;
  assign bus.valid_out = r_valid_out;
  assign bus.active    = r_active;

`ifdef RX_SYNC_STATS_EN
  logic [15:0] r_payload_cnt;

  // Saturating count of forwarded bytes; survives loss of lock
  always_ff @(posedge clk_2f) begin
    if (!reset) begin
      r_payload_cnt <= '0;
    end else if (w_valid_nxt && (r_payload_cnt != 16'hFFFF)) begin
      r_payload_cnt <= r_payload_cnt + 16'd1;
    end
  end

  assign bus.payload_cnt = r_payload_cnt;
`else
  // statistics counter not built
`endif

endmodule

// File: tb/tb_rx_byte_sync.sv
// Directed self-checking bench for rx_byte_sync (RX_SYNC_STATS_EN optional).
module tb_rx_byte_sync;
  logic clk_2f;
  logic rst_n;
  int   n_assert;
  int   n_fail;

  rx_byte_sync_if u_if ();

  rx_byte_sync #(
    .COMMA      (8'hBC),
    .IDLE       (8'h7C),
    .SYNC_COUNT (4),
    .LOSS_CYCLES(8)
  ) dut (
    .clk_2f(clk_2f),
    .reset (rst_n),
    .bus   (u_if.slave)
  );

  initial begin
    clk_2f = 1'b0;
    forever #5 clk_2f = ~clk_2f;
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [7:0] d, input logic v, input logic a);
    chk({tag, ".data"},   {8'h00, u_if.data_out}, {8'h00, d});
    chk({tag, ".valid"},  {15'h0, u_if.valid_out}, {15'h0, v});
    chk({tag, ".active"}, {15'h0, u_if.active},    {15'h0, a});
  endtask

  // drive one byte, advance one edge, settle
  task automatic step(input logic [7:0] b, input logic v);
    u_if.byte_in    = b;
    u_if.byte_valid = v;
    @(posedge clk_2f);
    #1;
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    u_if.byte_in    = 8'h00;
    u_if.byte_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk_2f);

    // reset with garbage on the input
    step(8'hAA, 1'b1);
    step(8'hAA, 1'b1);
    chk_out("reset", 8'h00, 1'b0, 1'b0);
    rst_n = 1'b1;

    // lock on four commas, then two payload bytes
    step(8'hBC, 1'b1); chk_out("lock_bc1", 8'h00, 1'b0, 1'b0);
    step(8'hBC, 1'b1);
    step(8'hBC, 1'b1); chk_out("lock_bc3", 8'h00, 1'b0, 1'b0);
    step(8'hBC, 1'b1); chk_out("lock_bc4", 8'h00, 1'b0, 1'b1);
    step(8'h11, 1'b1); chk_out("pay_11",   8'h11, 1'b1, 1'b1);
    step(8'h22, 1'b1); chk_out("pay_22",   8'h22, 1'b1, 1'b1);
    step(8'h7C, 1'b1); chk_out("idle_end", 8'h22, 1'b0, 1'b1);

    // mid-operation reset drops lock and clears data
    step(8'hBC, 1'b1);
    rst_n = 1'b0;
    step(8'hBC, 1'b1); chk_out("mid_reset", 8'h00, 1'b0, 1'b0);
    rst_n = 1'b1;

    // idle breaks a comma run
    step(8'hBC, 1'b1);
    step(8'hBC, 1'b1);
    step(8'h7C, 1'b1);
    step(8'hBC, 1'b1);
    step(8'hBC, 1'b1);
    step(8'hBC, 1'b1); chk_out("run_broken", 8'h00, 1'b0, 1'b0);
    step(8'hBC, 1'b1); chk_out("relock",     8'h00, 1'b0, 1'b1);

    // filter: 33,7C,BC,44,gap,55
    step(8'h33, 1'b1); chk_out("f_33",  8'h33, 1'b1, 1'b1);
    step(8'h7C, 1'b1); chk_out("f_7c",  8'h33, 1'b0, 1'b1);
    step(8'hBC, 1'b1); chk_out("f_bc",  8'h33, 1'b0, 1'b1);
    step(8'h44, 1'b1); chk_out("f_44",  8'h44, 1'b1, 1'b1);
    step(8'h99, 1'b0); chk_out("f_gap", 8'h44, 1'b0, 1'b1);
    step(8'h55, 1'b1); chk_out("f_55",  8'h55, 1'b1, 1'b1);

    // seven gaps then a valid idle keeps lock
    for (int i = 0; i < 7; i++) step(8'h00, 1'b0);
    chk_out("gap7", 8'h55, 1'b0, 1'b1);
    step(8'h7C, 1'b1);
    for (int i = 0; i < 7; i++) step(8'h00, 1'b0);
    chk_out("gap7_again", 8'h55, 1'b0, 1'b1);
    step(8'h00, 1'b0); chk_out("gap8_loss", 8'h55, 1'b0, 1'b0);

    // only three commas (gap in between) -> payload not forwarded
    step(8'hBC, 1'b1);
    step(8'h00, 1'b0);
    step(8'hBC, 1'b1);
    step(8'hBC, 1'b1);
    step(8'h66, 1'b1); chk_out("no_fwd_66", 8'h55, 1'b0, 1'b0);

    // a gap does not break a comma run
    step(8'hBC, 1'b1);
    step(8'hBC, 1'b1);
    step(8'hBC, 1'b1);
    step(8'h00, 1'b0); chk_out("gap_in_run", 8'h55, 1'b0, 1'b0);
    step(8'hBC, 1'b1); chk_out("lock_gap",   8'h55, 1'b0, 1'b1);
    step(8'h77, 1'b1); chk_out("pay_77",     8'h77, 1'b1, 1'b1);

`ifdef RX_SYNC_STATS_EN
    // 33,44,55,77 since the mid reset; loss of lock does not clear it
    chk("cnt_keep", u_if.payload_cnt, 16'd4);
    rst_n = 1'b0;
    step(8'h00, 1'b0); chk("cnt_reset", u_if.payload_cnt, 16'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) step(8'hBC, 1'b1);
    for (int i = 1; i <= 5; i++) step(8'(i), 1'b1);
    for (int i = 0; i < 3; i++) step(8'h7C, 1'b1);
    chk("cnt_5", u_if.payload_cnt, 16'd5);
    force dut.r_payload_cnt = 16'hFFFE;
    #1;
    release dut.r_payload_cnt;
    step(8'hA1, 1'b1); chk("cnt_sat1", u_if.payload_cnt, 16'hFFFF);
    step(8'hA2, 1'b1);
    step(8'hA3, 1'b1); chk("cnt_sat3", u_if.payload_cnt, 16'hFFFF);
`else
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
